// File: rtl/fetch_ctrl.sv
//------------------------------------------------------------------------------
// Module   : fetch_ctrl
// Purpose  : Instruction-fetch sequencer. Owns the PC, drives a req/ack
//            memory port and buffers one instruction toward decode.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module fetch_ctrl #(
  parameter int              ADDR_W   = 64,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              fetch_en,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [31:0]       imem_rdata,
  output logic              instr_valid,
  output logic [31:0]       instr,
  output logic [ADDR_W-1:0] instr_pc,
  input  logic              instr_ready,
  output logic [31:0]       fetch_count
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    HOLD    = 2'd2,
    DISCARD = 2'd3
  } state_t;

  state_t            r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_pc, w_pc_nxt;
  logic [ADDR_W-1:0] r_addr, w_addr_nxt;
  logic [31:0]       r_instr, w_instr_nxt;
  logic [ADDR_W-1:0] r_instr_pc, w_instr_pc_nxt;
  logic              r_valid, w_valid_nxt;
  logic [31:0]       r_count, w_count_nxt;

  logic [ADDR_W-1:0] w_redir_pc;
  logic [ADDR_W-1:0] w_pc_eff;

  // Redirect targets are word aligned; the low two bits are ignored.
  assign w_redir_pc = {redirect_pc[ADDR_W-1:2], 2'b00};
  assign w_pc_eff   = redirect ? w_redir_pc : r_pc;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= IDLE;
      r_pc       <= RESET_PC;
      r_addr     <= RESET_PC;
      r_instr    <= '0;
      r_instr_pc <= '0;
      r_valid    <= 1'b0;
      r_count    <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_pc       <= w_pc_nxt;
      r_addr     <= w_addr_nxt;
      r_instr    <= w_instr_nxt;
      r_instr_pc <= w_instr_pc_nxt;
      r_valid    <= w_valid_nxt;
      r_count    <= w_count_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_pc_nxt       = w_pc_eff;
    w_addr_nxt     = r_addr;
    w_instr_nxt    = r_instr;
    w_instr_pc_nxt = r_instr_pc;
    w_valid_nxt    = redirect ? 1'b0 : r_valid;
    w_count_nxt    = r_count;

    case (r_state)
      IDLE: begin
        if (fetch_en) begin
          w_state_nxt = REQ;
          w_addr_nxt  = w_pc_eff;
        end
      end

      REQ: begin
        if (redirect) begin
          // An acked word is stale; an un-acked request must still complete.
          if (imem_ack) begin
            w_state_nxt = fetch_en ? REQ : IDLE;
            if (fetch_en) w_addr_nxt = w_redir_pc;
          end else begin
            w_state_nxt = DISCARD;
          end
        end else if (imem_ack) begin
          w_instr_nxt    = imem_rdata;
          w_instr_pc_nxt = r_addr;
          w_valid_nxt    = 1'b1;
          w_pc_nxt       = r_pc + ADDR_W'(4);
          w_state_nxt    = HOLD;
        end
      end

      HOLD: begin
        if (redirect || instr_ready) begin
          w_valid_nxt = 1'b0;
          if (!redirect) w_count_nxt = r_count + 32'd1;
          w_state_nxt = fetch_en ? REQ : IDLE;
          if (fetch_en) w_addr_nxt = w_pc_eff;
        end
      end

      DISCARD: begin
        if (imem_ack) begin
          w_state_nxt = fetch_en ? REQ : IDLE;
          if (fetch_en) w_addr_nxt = w_pc_eff;
        end
      end

      default: w_state_nxt = IDLE;
    endcase
  end

  assign imem_req    = (r_state == REQ) || (r_state == DISCARD);
  assign imem_addr   = r_addr;
  assign instr_valid = r_valid;
  assign instr       = r_instr;
  assign instr_pc    = r_instr_pc;
  assign fetch_count = r_count;

endmodule

`default_nettype wire

// File: tb/tb_fetch_ctrl.sv
//------------------------------------------------------------------------------
// Module   : tb_fetch_ctrl
// Purpose  : Directed self-checking bench for fetch_ctrl.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_fetch_ctrl;

  localparam int ADDR_W = 64;

  logic              clk;
  logic              reset_n;
  logic              fetch_en;
  logic              redirect;
  logic [ADDR_W-1:0] redirect_pc;
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_ack;
  logic [31:0]       imem_rdata;
  logic              instr_valid;
  logic [31:0]       instr;
  logic [ADDR_W-1:0] instr_pc;
  logic              instr_ready;
  logic [31:0]       fetch_count;

  int n_total = 0;
  int n_bad   = 0;

  fetch_ctrl #(.ADDR_W(ADDR_W), .RESET_PC(64'd0)) u_dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .fetch_en   (fetch_en),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .instr_valid(instr_valid),
    .instr      (instr),
    .instr_pc   (instr_pc),
    .instr_ready(instr_ready),
    .fetch_count(fetch_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory returns a word tagged with the low address bits.
  assign imem_rdata = {16'hC0DE, imem_addr[15:0]};

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    step();
    step();
    reset_n = 1'b1;
  endtask

  initial begin
    reset_n     = 1'b0;
    fetch_en    = 1'b1;
    redirect    = 1'b0;
    redirect_pc = '0;
    imem_ack    = 1'b1;
    instr_ready = 1'b1;
    step();
    check_eq("rst_req",   imem_req,    0);
    check_eq("rst_addr",  imem_addr,   0);
    check_eq("rst_valid", instr_valid, 0);
    check_eq("rst_instr", instr,       0);
    check_eq("rst_ipc",   instr_pc,    0);
    check_eq("rst_count", fetch_count, 0);

    // Back-to-back fetch with zero-wait memory
    do_reset();
    step(); check_eq("t1_addr0", imem_addr, 64'h0); check_eq("t1_req0", imem_req, 1);
    step(); check_eq("t1_ipc0", instr_pc, 64'h0); check_eq("t1_ins0", instr, 32'hC0DE0000);
            check_eq("t1_v0", instr_valid, 1);
    step(); check_eq("t1_addr1", imem_addr, 64'h4); check_eq("t1_cnt1", fetch_count, 1);
    step(); check_eq("t1_ipc1", instr_pc, 64'h4);
    step(); check_eq("t1_addr2", imem_addr, 64'h8); check_eq("t1_cnt2", fetch_count, 2);
    step(); check_eq("t1_ipc2", instr_pc, 64'h8);
    step(); check_eq("t1_cnt3", fetch_count, 3);

    // Wait states at 0x4, then stall in HOLD
    do_reset();
    step(); step(); step();
    check_eq("t2_addr", imem_addr, 64'h4);
    imem_ack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check_eq("t2_req_hold",  imem_req,    1);
      check_eq("t2_addr_hold", imem_addr,   64'h4);
      check_eq("t2_no_valid",  instr_valid, 0);
    end
    imem_ack = 1'b1;
    step();
    check_eq("t2_valid", instr_valid, 1);
    check_eq("t2_instr", instr, 32'hC0DE0004);
    check_eq("t2_ipc",   instr_pc, 64'h4);
    instr_ready = 1'b0;
    imem_ack    = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      check_eq("t3_valid", instr_valid, 1);
      check_eq("t3_instr", instr, 32'hC0DE0004);
      check_eq("t3_ipc",   instr_pc, 64'h4);
      check_eq("t3_req",   imem_req, 0);
      check_eq("t3_cnt",   fetch_count, 1);
    end
    instr_ready = 1'b1;
    step();
    check_eq("t3_cnt_inc", fetch_count, 2);
    check_eq("t3_next",    imem_addr, 64'h8);
    check_eq("t3_req_on",  imem_req, 1);

    // Redirect while the 0x8 request is outstanding
    redirect    = 1'b1;
    redirect_pc = 64'h103;
    step();
    redirect = 1'b0;
    check_eq("t4_req",  imem_req, 1);
    check_eq("t4_addr", imem_addr, 64'h8);
    check_eq("t4_v",    instr_valid, 0);
    step();
    check_eq("t4_addr_hold", imem_addr, 64'h8);
    imem_ack = 1'b1;
    step();
    check_eq("t4_newaddr", imem_addr, 64'h100);
    check_eq("t4_v_after", instr_valid, 0);
    check_eq("t4_stale",   instr, 32'hC0DE0004);
    step();
    check_eq("t4_ipc", instr_pc, 64'h100);
    check_eq("t4_ins", instr, 32'hC0DE0100);

    // Redirect in HOLD with a same-cycle ready
    redirect    = 1'b1;
    redirect_pc = 64'h200;
    step();
    redirect = 1'b0;
    check_eq("t5_v",    instr_valid, 0);
    check_eq("t5_cnt",  fetch_count, 2);
    check_eq("t5_addr", imem_addr, 64'h200);

    // Asynchronous reset mid-request
    imem_ack = 1'b0;
    step();
    check_eq("t6_req_pre", imem_req, 1);
    reset_n = 1'b0;
    #1;
    check_eq("t6_req",   imem_req, 0);
    check_eq("t6_v",     instr_valid, 0);
    check_eq("t6_addr",  imem_addr, 64'h0);
    check_eq("t6_cnt",   fetch_count, 0);
    step();
    reset_n  = 1'b1;
    imem_ack = 1'b1;
    step();
    check_eq("t6_first", imem_addr, 64'h0);

    // Redirect with same-cycle ack, then PC wrap
    redirect    = 1'b1;
    redirect_pc = 64'hFFFF_FFFF_FFFF_FFFE;
    step();
    redirect = 1'b0;
    check_eq("w_addr", imem_addr, 64'hFFFF_FFFF_FFFF_FFFC);
    check_eq("w_v",    instr_valid, 0);
    step();
    check_eq("w_ipc",  instr_pc, 64'hFFFF_FFFF_FFFF_FFFC);
    check_eq("w_ins",  instr, 32'hC0DEFFFC);
    step();
    check_eq("w_wrap", imem_addr, 64'h0);
    check_eq("w_cnt",  fetch_count, 1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
Sequencing controller for instruction fetch in the pipelined CPU. It owns the PC register, issues requests to a variable-latency instruction memory over a req/ack handshake, and buffers one fetched instruction toward decode over a valid/ready handshake. It accepts branch/BR redirects from execute, and it discards in-flight or buffered fetches that a redirect makes stale.

Parameters:
ADDR_W, 64, PC and memory address width
RESET_PC, 64'd0, PC value loaded on reset

Ports:
clk  in  1  system clock, rising edge
reset_n  in  1  asynchronous reset, active-low
fetch_en  in  1  permit new fetch requests
redirect  in  1  taken branch / BR from execute
redirect_pc  in  ADDR_W  redirect target
imem_req  out  1  memory request
imem_addr  out  ADDR_W  memory request address
imem_ack  in  1  memory response strobe, qualified by imem_req
imem_rdata  in  32  instruction word, valid with imem_ack
instr_valid  out  1  instr/instr_pc valid to decode
instr  out  32  buffered instruction
instr_pc  out  ADDR_W  PC of buffered instruction
instr_ready  in  1  decode accepts instruction
fetch_count  out  32  count of delivered instructions

Behaviour:
- Reset (reset_n=0, asynchronous): state=IDLE, pc=RESET_PC, imem_addr=RESET_PC, imem_req=0, instr_valid=0, instr=0, instr_pc=0, fetch_count=0. An outstanding memory request is abandoned without waiting for ack.
- States: IDLE, REQ, HOLD, DISCARD. imem_req=1 exactly in REQ and DISCARD. imem_addr is a register loaded only on entry to REQ and held stable until ack.
- IDLE: if fetch_en=1, then next state is REQ and imem_addr<=pc.
- REQ: on imem_ack=1, instr<=imem_rdata, instr_pc<=imem_addr, instr_valid<=1, pc<=pc+4, next state HOLD. Without ack, remain in REQ. fetch_en=0 while in REQ does not cancel the request.
- HOLD: instr_valid=1, and instr/instr_pc are held. On instr_ready=1: instr_valid<=0, fetch_count<=fetch_count+1, next state REQ (imem_addr<=pc) if fetch_en=1, else IDLE.
- Latency: ack in cycle N gives instr_valid=1 in cycle N+1. With zero-wait memory and ready held high, one instruction is delivered every 2 cycles.
- Redirect has the highest priority, in every state:
  - pc<=redirect_pc with bits [1:0] forced to 00.
  - instr_valid<=0.
  - A same-cycle valid/ready handshake is NOT counted.
- Redirect per state:
  - IDLE: goes to REQ with the new pc if fetch_en=1, else stays IDLE.
  - REQ without ack: goes to DISCARD. The memory handshake cannot be aborted; imem_req stays 1 and imem_addr stays at the old address.
  - REQ with ack in the same cycle: rdata is dropped; goes to REQ with the new pc if fetch_en=1, else IDLE.
  - HOLD: the buffered instruction is dropped; goes to REQ with the new pc if fetch_en=1, else IDLE.
  - DISCARD: pc is updated (the latest redirect wins). Stays DISCARD, unless ack arrives in the same cycle, in which case the DISCARD ack rule applies using the updated pc.
- DISCARD: on imem_ack=1, rdata is dropped and pc is not incremented; goes to REQ (imem_addr<=pc) if fetch_en=1, else IDLE.
- imem_ack seen while imem_req=0 is ignored.
- Arithmetic: pc+4 wraps modulo 2^ADDR_W. fetch_count wraps modulo 2^32.
- X-free: all outputs are driven from registers or the state decode, with no combinational path from inputs to outputs.

Test Plan:
1. Hold reset_n=0, then release with fetch_en=1, zero-wait ack, ready=1 -> imem_addr sequence 0x0, 0x4, 0x8. Each instr_pc equals its request address. fetch_count=3 after three deliveries.
2. Hold ack off for 3 cycles at address 0x4 -> imem_req=1 and imem_addr=0x4 stable throughout. instr_valid rises exactly one cycle after ack, and instr equals the rdata presented with ack.
3. instr_ready=0 for 5 cycles in HOLD -> instr, instr_pc and instr_valid are held, imem_req=0, and fetch_count is unchanged. Raising ready -> count increments and the next request is at instr_pc+4.
4. Assert redirect to 0x103 while REQ at 0x8 is outstanding -> DISCARD with imem_addr=0x8 held. The late ack data never appears on instr, and the next request is at 0x100.
5. Assert redirect to 0x200 in HOLD in the same cycle as instr_ready=1 -> instr_valid=0, fetch_count unchanged, next imem_addr=0x200.
6. Assert reset_n=0 mid-REQ -> imem_req=0, instr_valid=0, pc=RESET_PC immediately. After release, the first request is at 0x0.
